led_breathe: RTL
================

Name: led_breathe

Overview:
- Downstream consumer of the PLL clock domain: drives a board LED with a "breathing" pattern instead of a plain 1 s toggle.
- Internal prescaler produces brightness steps. An FSM ramps a duty level up, holds it, ramps it down, holds it again.
- A free-running PWM comparator turns the level into an active-low LED drive.
- Gated by the PLL lock indication so the LED stays dark until sysclk is stable.

Parameters:
- PWM_BITS, 8, width of PWM counter and brightness level; LEVEL_MAX = 2**PWM_BITS-1.
- PRESCALE, 131072, sysclk cycles per brightness step (≥2). Gives ≈2.5 s per full breath at 33 MHz.
- HOLD_STEPS, 64, steps spent in each hold state (≥1).

Ports:
- sysclk  input  1  system clock from PLL c0
- nRESET  input  1  reset, synchronous, active-low
- locked  input  1  PLL lock; low forces idle
- enable  input  1  request breathing
- LED_n  output  1  LED drive, active-low, registered
- level  output  PWM_BITS  current brightness level
- busy  output  1  high whenever FSM not IDLE

Behaviour:
- Reset (nRESET low at sysclk edge): state=IDLE, level=0, prescaler=0, hold_cnt=0, pwm_cnt=0, LED_n=1, busy=0.
- locked low: same effect as reset, evaluated every cycle; reset has priority over locked.
- Prescaler:
  - Counts 0..PRESCALE-1 only while state≠IDLE, then wraps to 0.
  - step = 1 for one cycle when count==PRESCALE-1.
  - Cleared on entry to IDLE.
- PWM:
  - pwm_cnt free-running PWM_BITS counter, wraps LEVEL_MAX→0.
  - LED_n <= !(pwm_cnt < duty); duty = level (see optional feature).
  - Latency: one sysclk cycle from compare to LED_n.
  - level=0: LED_n constantly 1. level=LEVEL_MAX: on LEVEL_MAX of every 2**PWM_BITS cycles.
- FSM states: IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO.
  - IDLE: enable&&locked → RAMP_UP next cycle; level stays 0.
  - RAMP_UP:
    - On step with level<LEVEL_MAX: level+1.
    - On step with level==LEVEL_MAX: → HOLD_HI, hold_cnt=0.
  - HOLD_HI:
    - On step: hold_cnt+1.
    - On step with hold_cnt==HOLD_STEPS-1: → RAMP_DOWN, hold_cnt=0.
  - RAMP_DOWN:
    - On step with level>0: level-1.
    - On step with level==0: → HOLD_LO, hold_cnt=0.
  - HOLD_LO:
    - On step with hold_cnt==HOLD_STEPS-1: enable → RAMP_UP, else → IDLE.
    - Otherwise on step: hold_cnt+1.
- Graceful stop: enable deasserted mid-cycle does not abort. Breath completes, stops at end of HOLD_LO, LED never jumps bright→dark.
- Enable re-asserted before HOLD_LO ends: continues seamlessly.
- level never wraps: saturates by construction at 0 and LEVEL_MAX.
- busy = (state≠IDLE), registered with state.

Optional Feature:
- Macro LED_BREATHE_GAMMA_EN.
- Defined: duty = (level*level) >> PWM_BITS, truncated, a gamma-2 perceptual curve. level=LEVEL_MAX yields duty=LEVEL_MAX-1.
- Undefined: duty = level, linear. Ports and FSM timing are identical in both builds.

Decomposition:
- Package led_breathe_pkg: enum typedef breathe_state_t (IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO) and the default PRESCALE/HOLD_STEPS constants.
- Sub-module led_pwm: pwm_cnt plus registered compare. Ports sysclk, nRESET, duty, LED_n. Reused by future LED blocks.

Test Plan (PWM_BITS=4, PRESCALE=4, HOLD_STEPS=2 unless noted):
- Reset held 3 cycles, enable=1, locked=1 → LED_n=1, level=0, busy=0 throughout. Release → busy=1 two cycles after release.
- Full breath:
  - level 0→15, increment every 4 cycles.
  - 15 holds for the final ramp step plus 2 hold steps.
  - Ramps 15→0, holds, returns to RAMP_UP.
  - One full period = 4*(16+2+16+2)=144 cycles.
- Duty check at level=5 (linear build): exactly 5 LED_n-low cycles per 16-cycle PWM window. level=0 → zero low cycles.
- enable dropped during RAMP_UP at level=7 → completes breath; busy falls one cycle after HOLD_LO final step; level=0, LED_n=1.
- locked dropped during HOLD_HI → next cycle state=IDLE, level=0, LED_n=1 one cycle later. locked restored with enable=1 → restarts from level 0.
- LED_BREATHE_GAMMA_EN defined, level=15 → duty=14 (14 low cycles/16); level=3 → duty=0 (LED dark).

Source files
------------

// File: rtl/led_breathe_pkg.sv
// -----------------------------------------------------------------------------
// led_breathe_pkg
//   Shared types and constants for the LED breathing block.
//   - breathe_state_t : FSM state encoding (IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN,
//                       HOLD_LO).
//   - DEFAULT_*       : default parameter values (8-bit PWM, 131072-cycle
//                       brightness step, 64-step holds).
//   - cnt_width()     : counter width for a modulus n, never less than 1 bit.
// -----------------------------------------------------------------------------
package led_breathe_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } breathe_state_t;

  localparam int DEFAULT_PWM_BITS   = 8;
  localparam int DEFAULT_PRESCALE   = 131072;
  localparam int DEFAULT_HOLD_STEPS = 64;

  // Bits needed to count 0..n-1; a modulus of 1 still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// -----------------------------------------------------------------------------
// led_pwm
//   Free-running PWM generator for an active-low LED.
//   pwm_cnt counts 0..2**PWM_BITS-1 and wraps; LED_n is the registered result
//   of (pwm_cnt < duty), inverted, so the LED is lit for 'duty' cycles out of
//   every 2**PWM_BITS. One cycle of latency from compare to LED_n.
//
// Ports:
//   sysclk  in   clock
//   nRESET  in   synchronous active-low reset (pwm_cnt=0, LED_n=1)
//   duty    in   [PWM_BITS-1:0] on-time per PWM window
//   LED_n   out  registered LED drive, active-low
// -----------------------------------------------------------------------------
module led_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                sysclk,
  input  logic                nRESET,
  input  logic [PWM_BITS-1:0] duty,
  output logic                LED_n
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge sysclk) begin
    if (!nRESET) begin
      pwm_cnt <= '0;
      LED_n   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LED_n   <= !(pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/led_breathe.sv
// -----------------------------------------------------------------------------
// led_breathe
//   Drives a board LED with a "breathing" pattern: brightness ramps up, holds,
//   ramps down, holds, and repeats while 'enable' is high. A prescaler turns
//   sysclk into brightness steps; a PWM comparator (led_pwm) turns the level
//   into an active-low drive. Dropping 'enable' lets the current breath finish
//   at the dark end of HOLD_LO, so the LED never snaps from bright to dark.
//   'locked' low acts exactly like reset so the LED stays dark until the PLL
//   clock is stable.
//
// Ports:
//   sysclk  in   system clock (PLL c0)
//   nRESET  in   synchronous active-low reset
//   locked  in   PLL lock; low forces everything back to idle
//   enable  in   request breathing
//   LED_n   out  registered LED drive, active-low
//   level   out  [PWM_BITS-1:0] current brightness level
//   busy    out  high whenever the FSM is not IDLE (registered with state)
//
// Build option:
//   LED_BREATHE_GAMMA_EN  defined   : duty = (level*level) >> PWM_BITS
//                         undefined : duty = level (linear)
// -----------------------------------------------------------------------------
module led_breathe
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int HOLD_STEPS = DEFAULT_HOLD_STEPS
) (
  input  logic                sysclk,
  input  logic                nRESET,
  input  logic                locked,
  input  logic                enable,
  output logic                LED_n,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int PS_W   = cnt_width(PRESCALE);
  localparam int HOLD_W = cnt_width(HOLD_STEPS);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  breathe_state_t      state;
  logic [PS_W-1:0]     presc;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                step;
  logic                run_n;
  logic [PWM_BITS-1:0] duty;

  // Lock loss is treated as a reset for the whole block, PWM included.
  assign run_n = nRESET && locked;

  // Prescaler is held at 0 in IDLE, so a step can only fire while breathing.
  assign step = (state != IDLE) && (presc == PS_LAST);

  always_ff @(posedge sysclk) begin
    if (!run_n) begin
      state    <= IDLE;
      level    <= '0;
      presc    <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      // Wrapping on every step also clears the prescaler on entry to IDLE,
      // since IDLE is only ever entered on a step.
      if (state == IDLE || step) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= RAMP_UP;
            busy  <= 1'b1;
          end
        end

        RAMP_UP: begin
          if (step) begin
            if (level == LEVEL_MAX) begin
              state    <= HOLD_HI;
              hold_cnt <= '0;
            end else begin
              level <= level + 1'b1;
            end
          end
        end

        HOLD_HI: begin
          if (step) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= RAMP_DOWN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        RAMP_DOWN: begin
          if (step) begin
            if (level == '0) begin
              state    <= HOLD_LO;
              hold_cnt <= '0;
            end else begin
              level <= level - 1'b1;
            end
          end
        end

        HOLD_LO: begin
          // Only exit point of a breath: enable is sampled here, which is
          // what makes a stop graceful and a re-enable seamless.
          if (step) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (enable) begin
                state <= RAMP_UP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_BREATHE_GAMMA_EN
  // Gamma-2 curve: keep the upper half of level^2. The low half is the
  // truncated fraction and is intentionally dropped.
  logic [PWM_BITS-1:0] gamma_frac_unused;
  logic [PWM_BITS-1:0] level_lo;
  logic [PWM_BITS-1:0] level_hi_zero;

  assign level_lo      = level;
  assign level_hi_zero = '0;
  assign {duty, gamma_frac_unused} = {level_hi_zero, level_lo} * {level_hi_zero, level_lo};
`else
  assign duty = level;
`endif

  led_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .sysclk (sysclk),
    .nRESET (run_n),
    .duty   (duty),
    .LED_n  (LED_n)
  );

endmodule
